// File: rtl/stream_test_sequencer.sv
// Repeats captures on the stream test sink and sums the sink's per-packet counts
// into run totals; supports inter-packet gap, per-packet timeout and abort.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | after reset, waiting for run
// S_START | one-cycle sink_start pulse
// S_RUN   | sink capturing; wait for sink_idle or timeout
// S_GAP   | idle cycles between packet completion and the next start
// S_DONE  | results held until the next accepted run
module stream_test_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_packets,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [31:0]      cfg_timeout,
  output logic             sink_start,
  input  logic             sink_idle,
  input  logic [31:0]      sink_beats,
  input  logic [31:0]      sink_misses,
  input  logic [31:0]      sink_errors,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             aborted,
  output logic [CNT_W-1:0] packets_done,
  output logic [CNT_W-1:0] bad_packets,
  output logic [31:0]      total_beats,
  output logic [31:0]      total_misses,
  output logic [31:0]      total_errors
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_GAP, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pkts_r, gap_r, gap_cnt, packets_inc;
  logic [31:0]      timeout_r, run_cnt;
  logic             accept, complete, tmo_hit, abort_hit;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign packets_inc = packets_done + 1'b1;
  assign busy = (state == S_START) || (state == S_RUN) || (state == S_GAP);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      sink_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      sink_start <= (state_nxt == S_START);
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    tmo_hit   = 1'b0;
    abort_hit = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (run) begin
          accept    = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = S_DONE;
        end else if (sink_idle) begin
          complete = 1'b1;
          if ((pkts_r != '0) && (packets_inc == pkts_r)) state_nxt = S_DONE;
          else if (gap_r == '0)                          state_nxt = S_START;
          else                                           state_nxt = S_GAP;
        end else if ((timeout_r != 32'd0) && (run_cnt == timeout_r - 32'd1)) begin
          // run_cnt counts elapsed RUN cycles before this one
          tmo_hit   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_GAP: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = S_DONE;
        end else if (gap_cnt == '0) begin
          state_nxt = S_START;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkts_r       <= '0;
      gap_r        <= '0;
      timeout_r    <= '0;
      gap_cnt      <= '0;
      run_cnt      <= '0;
      packets_done <= '0;
      bad_packets  <= '0;
      total_beats  <= '0;
      total_misses <= '0;
      total_errors <= '0;
      timed_out    <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      if (accept) begin
        pkts_r       <= cfg_packets;
        gap_r        <= cfg_gap;
        timeout_r    <= cfg_timeout;
        packets_done <= '0;
        bad_packets  <= '0;
        total_beats  <= '0;
        total_misses <= '0;
        total_errors <= '0;
        timed_out    <= 1'b0;
        aborted      <= 1'b0;
      end
      if (state == S_START) run_cnt <= '0;
      else if (state == S_RUN) run_cnt <= run_cnt + 32'd1;
      if (complete) begin
        total_beats  <= sat_add(total_beats, sink_beats);
        total_misses <= sat_add(total_misses, sink_misses);
        total_errors <= sat_add(total_errors, sink_errors);
        packets_done <= packets_inc;
        if (sink_errors != 32'd0) bad_packets <= bad_packets + 1'b1;
        gap_cnt <= gap_r - 1'b1;
      end else if ((state == S_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      if (tmo_hit)   timed_out <= 1'b1;
      if (abort_hit) aborted   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_test_sequencer.sv
// Directed bench for stream_test_sequencer: single packet, gapped multi-packet,
// coincident completion, timeout, abort, saturation and async reset.
module tb_stream_test_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             run = 1'b0, abort = 1'b0;
  logic [CNT_W-1:0] cfg_packets = '0, cfg_gap = '0;
  logic [31:0]      cfg_timeout = '0;
  logic             sink_start;
  logic             sink_idle = 1'b1;
  logic [31:0]      sink_beats = '0, sink_misses = '0, sink_errors = '0;
  logic             busy, done, timed_out, aborted;
  logic [CNT_W-1:0] packets_done, bad_packets;
  logic [31:0]      total_beats, total_misses, total_errors;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;

  stream_test_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .run(run), .abort(abort),
    .cfg_packets(cfg_packets), .cfg_gap(cfg_gap), .cfg_timeout(cfg_timeout),
    .sink_start(sink_start), .sink_idle(sink_idle),
    .sink_beats(sink_beats), .sink_misses(sink_misses), .sink_errors(sink_errors),
    .busy(busy), .done(done), .timed_out(timed_out), .aborted(aborted),
    .packets_done(packets_done), .bad_packets(bad_packets),
    .total_beats(total_beats), .total_misses(total_misses), .total_errors(total_errors)
  );

  always #5 clk = ~clk;

  // cycle index as seen at posedge+1 equals the cyc value recorded here
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sink_start) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!sink_start && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_start_seen"}, {31'd0, sink_start}, 32'd1);
  endtask

  initial begin
    int s0, k;

    // reset state
    #12;
    chk("rst_sink_start", {31'd0, sink_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pkts", {16'd0, packets_done}, 32'd0);
    chk("rst_beats", total_beats, 32'd0);
    resetn = 1'b1;
    tick();

    // single packet
    cfg_packets = 16'd1; cfg_gap = 16'd0; cfg_timeout = 32'd0;
    sink_idle = 1'b0;
    s0 = start_cnt;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t1_start_pulse", {31'd0, sink_start}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_run_no_start", {31'd0, sink_start}, 32'd0);
    tick();
    sink_beats = 32'd100; sink_misses = 32'd5; sink_errors = 32'd0;
    sink_idle = 1'b1;
    tick();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_not_busy", {31'd0, busy}, 32'd0);
    chk("t1_beats", total_beats, 32'd100);
    chk("t1_misses", total_misses, 32'd5);
    chk("t1_errors", total_errors, 32'd0);
    chk("t1_pkts", {16'd0, packets_done}, 32'd1);
    chk("t1_bad", {16'd0, bad_packets}, 32'd0);
    tick(); tick(); tick();
    chk("t1_one_pulse", start_cnt - s0, 32'd1);
    chk("t1_done_hold", {31'd0, done}, 32'd1);

    // three packets, gap 4, errors on packet 2
    cfg_packets = 16'd3; cfg_gap = 16'd4;
    sink_idle = 1'b0; sink_misses = 32'd0;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t2_cleared", total_beats, 32'd0);
    for (int p = 0; p < 3; p++) begin
      tick();
      tick();
      sink_beats = 32'd10;
      sink_errors = (p == 1) ? 32'd1 : 32'd0;
      sink_idle = 1'b1;
      k = cyc;
      tick();
      sink_idle = 1'b0;
      if (p < 2) begin
        chk("t2_gap_state", {31'd0, busy & ~sink_start}, 32'd1);
        wait_start("t2");
        chk("t2_gap_spacing", cyc - k, 32'd5);
      end
    end
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_beats", total_beats, 32'd30);
    chk("t2_errors", total_errors, 32'd1);
    chk("t2_bad", {16'd0, bad_packets}, 32'd1);
    chk("t2_pkts", {16'd0, packets_done}, 32'd3);

    // completion coincident with the first RUN cycle
    cfg_packets = 16'd1; cfg_gap = 16'd0;
    sink_beats = 32'd7; sink_misses = 32'd2; sink_errors = 32'd3;
    sink_idle = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_beats", total_beats, 32'd7);
    chk("t3_misses", total_misses, 32'd2);
    chk("t3_errors", total_errors, 32'd3);
    chk("t3_bad", {16'd0, bad_packets}, 32'd1);

    // timeout after 20 RUN cycles
    cfg_timeout = 32'd20; sink_idle = 1'b0; sink_beats = 32'd55;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t4_not_yet", {31'd0, done}, 32'd0);
    tick();
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_timed_out", {31'd0, timed_out}, 32'd1);
    chk("t4_beats", total_beats, 32'd0);
    chk("t4_pkts", {16'd0, packets_done}, 32'd0);

    // continuous run, saturation, abort on the 3rd RUN
    cfg_packets = 16'd0; cfg_timeout = 32'd0;
    sink_beats = 32'hFFFF_FFF0; sink_misses = 32'd1; sink_errors = 32'd0;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t5_cleared_to", {31'd0, timed_out}, 32'd0);
    tick();
    sink_idle = 1'b1;
    tick();
    sink_idle = 1'b0;
    chk("t5_restart", {31'd0, sink_start}, 32'd1);
    chk("t5_beats1", total_beats, 32'hFFFF_FFF0);
    tick();
    sink_idle = 1'b1;
    tick();
    sink_idle = 1'b0;
    chk("t5_beats_sat", total_beats, 32'hFFFF_FFFF);
    tick();
    abort = 1'b1; sink_idle = 1'b1;
    tick();
    abort = 1'b0; sink_idle = 1'b0;
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_aborted", {31'd0, aborted}, 32'd1);
    chk("t5_pkts", {16'd0, packets_done}, 32'd2);
    chk("t5_misses", total_misses, 32'd2);
    chk("t5_beats_held", total_beats, 32'hFFFF_FFFF);
    abort = 1'b1;
    tick();
    chk("t5_abort_in_done", {31'd0, done}, 32'd1);
    run = 1'b1;
    tick();
    run = 1'b0; abort = 1'b0;
    chk("t5_run_wins", {31'd0, sink_start}, 32'd1);
    chk("t5_aborted_clr", {31'd0, aborted}, 32'd0);

    // async reset mid-RUN
    tick();
    sink_idle = 1'b1;
    tick();
    sink_idle = 1'b0;
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_sink_start", {31'd0, sink_start}, 32'd0);
    chk("t6_pkts", {16'd0, packets_done}, 32'd0);
    chk("t6_beats", total_beats, 32'd0);
    chk("t6_misses", total_misses, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_test_sequencer.md
# stream_test_sequencer

Sequences repeated captures on the AXI4-Stream test sink: it issues the sink's single-cycle start pulse, waits for the sink to return idle, and adds the sink's per-packet beat, miss and error counts into run-level totals. It supports an inter-packet gap, a per-packet timeout and abort. It sits between the software register interface and the test sink, so a single run command measures N packets without processor involvement.

## Interface
Parameters:
- CNT_W, 16, width of the cfg_packets, cfg_gap, packets_done and bad_packets fields

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- run  in  1  start command; accepted only in IDLE or DONE
- abort  in  1  stop the current run; ignored in IDLE and DONE
- cfg_packets  in  CNT_W  packets per run; 0 = continuous until abort
- cfg_gap  in  CNT_W  idle cycles between packet completion and the next sink_start
- cfg_timeout  in  32  maximum RUN cycles per packet; 0 = no timeout
- sink_start  out  1  start pulse to the sink
- sink_idle  in  1  idle output of the sink
- sink_beats, sink_misses, sink_errors  in  32 each  sink counters
- busy  out  1  high in START, RUN and GAP
- done  out  1  high in DONE
- timed_out  out  1  the last run ended by timeout
- aborted  out  1  the last run ended by abort
- packets_done  out  CNT_W  completed packets in this run
- bad_packets  out  CNT_W  completed packets with sink_errors ≠ 0
- total_beats, total_misses, total_errors  out  32 each  saturating sums over completed packets

## Operation
- States: IDLE, START, RUN, GAP, DONE. Reset enters IDLE.
- Accepting run in IDLE or DONE does the following at that edge:
  - latch cfg_packets, cfg_gap and cfg_timeout into internal registers; cfg inputs are ignored at all other times;
  - clear all totals and counts, timed_out and aborted;
  - go to START.
- START lasts exactly 1 cycle with sink_start = 1, then goes to RUN. sink_start is a registered output and is 0 in every other state.
- RUN:
  - A per-packet cycle counter is cleared on entry and increments each RUN cycle.
  - Completion is sink_idle = 1 in any RUN cycle, including the first. This covers tlast arriving together with start.
  - On completion, at that edge:
    - add the sink counters into the totals, saturating at 0xFFFFFFFF;
    - increment packets_done (wraps);
    - increment bad_packets (wraps) if sink_errors ≠ 0.
  - After completion, the next state is chosen as follows:
    - if cfg_packets ≠ 0 and the new packets_done equals cfg_packets, go to DONE;
    - else if cfg_gap = 0, go to START;
    - else go to GAP.
  - Timeout: if cfg_timeout ≠ 0, the counter reaches cfg_timeout, and sink_idle = 0, set timed_out and go to DONE with no accumulation.
- GAP: counts cfg_gap cycles, then goes to START. Every gap cycle is spent in GAP.
- abort in START, RUN or GAP sets aborted and goes to DONE at the next edge.
  - Abort has priority over completion and timeout in the same cycle.
  - The in-flight packet is not accumulated.
- DONE holds all results stable until the next accepted run. run and abort in the same cycle while in DONE: run wins.
- Sink counters are read only on the completion edge. They are stable then because the sink holds its counters while idle.

## Timing
- Reset values:
  - sink_start = 0, busy = 0, done = 0, timed_out = 0, aborted = 0;
  - all counts and totals = 0.
- run sampled at edge 0 → sink_start = 1 in cycle 1 → RUN from cycle 2.
- Completion seen in cycle k gives these results:
  - totals are updated at the edge ending cycle k;
  - with gap = 0, sink_start = 1 in cycle k+1;
  - with gap = G, sink_start = 1 in cycle k+G+1.
- Timeout: with cfg_timeout = T and no completion, DONE is entered at the edge after the T-th RUN cycle.
- busy and done are decoded from the registered state and are never both 1.
- Asserting resetn low at any time returns the block to IDLE immediately (asynchronous) and clears all outputs. The sink is not reset by this block.

## Test plan
- Single packet: cfg_packets = 1, cfg_gap = 0; sink completes with beats = 100, misses = 5, errors = 0 → exactly one sink_start pulse; done = 1; total_beats = 100, total_misses = 5, total_errors = 0, packets_done = 1, bad_packets = 0.
- Multi-packet with gap: cfg_packets = 3, cfg_gap = 4; each packet has beats = 10 and errors = 1 on packet 2 only → sink_start pulses exactly 5 cycles after each completion cycle; total_beats = 30, total_errors = 1, bad_packets = 1.
- Coincident completion: sink_idle stays 1 through the first RUN cycle → completion is accepted on that cycle and the sink's counter values are accumulated.
- Timeout: cfg_timeout = 20; sink never returns idle → DONE 20 RUN cycles after entry; timed_out = 1; totals = 0.
- Abort and saturation:
  - cfg_packets = 0; abort during the 3rd RUN → aborted = 1, packets_done = 2.
  - Preload sink_beats = 0xFFFFFFF0 per packet → total_beats saturates at 0xFFFFFFFF.
  - Reset asserted mid-RUN → all outputs are 0 immediately.
